// File: rtl/cv32e40p_hwloop_bank.sv
// Hardware-loop register bank: per-loop start/end/counter with armed/done tracking and a readback port.
// All outputs are registered; writes, decrements and readback results appear after the next clk edge.
module cv32e40p_hwloop_bank #(
  parameter int N_LOOPS    = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int N_REG_BITS = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  hwlp_start_data_i,
  input  logic [31:0]                  hwlp_end_data_i,
  input  logic [CNT_WIDTH-1:0]         hwlp_cnt_data_i,
  input  logic [2:0]                   hwlp_we_i,
  input  logic [N_REG_BITS-1:0]        hwlp_regid_i,
  input  logic                         valid_i,
  input  logic [N_LOOPS-1:0]           hwlp_dec_cnt_i,
  input  logic                         flush_i,
  input  logic                         err_clr_i,
  input  logic                         rd_en_i,
  input  logic [N_REG_BITS-1:0]        rd_regid_i,
  input  logic [1:0]                   rd_sel_i,
  output logic [N_LOOPS*32-1:0]        hwlp_start_addr_o,
  output logic [N_LOOPS*32-1:0]        hwlp_end_addr_o,
  output logic [N_LOOPS*CNT_WIDTH-1:0] hwlp_counter_o,
  output logic [N_LOOPS-1:0]           hwlp_armed_o,
  output logic [N_LOOPS-1:0]           hwlp_done_o,
  output logic [31:0]                  rd_data_o,
  output logic                         rd_valid_o,
  output logic                         multi_dec_err_o
);

  logic [31:0]          start_q [N_LOOPS];
  logic [31:0]          start_d [N_LOOPS];
  logic [31:0]          end_q   [N_LOOPS];
  logic [31:0]          end_d   [N_LOOPS];
  logic [CNT_WIDTH-1:0] cnt_q   [N_LOOPS];
  logic [CNT_WIDTH-1:0] cnt_d   [N_LOOPS];
  logic [N_LOOPS-1:0]   armed_q, armed_d;
  logic [N_LOOPS-1:0]   done_q, done_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 err_q, err_d;

  logic [31:0]          wr_idx, rd_idx;
  logic                 dec_single, dec_multi;
  logic [N_LOOPS-1:0]   wr_hit, dec_eff, dec_last;
  logic [31:0]          rd_sel_val;

  // Out-of-range indices match no loop, so they write nothing and read back zero.
  assign wr_idx     = 32'(hwlp_regid_i);
  assign rd_idx     = 32'(rd_regid_i);
  assign dec_single = valid_i && $onehot(hwlp_dec_cnt_i);
  assign dec_multi  = valid_i && !$onehot0(hwlp_dec_cnt_i);

  always_comb begin
    armed_d = armed_q;
    done_d  = '0;
    wr_hit  = '0;
    dec_eff = '0;
    dec_last = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      start_d[k] = start_q[k];
      end_d[k]   = end_q[k];
      cnt_d[k]   = cnt_q[k];
      wr_hit[k]   = (wr_idx == 32'(k));
      dec_eff[k]  = dec_single && hwlp_dec_cnt_i[k] && armed_q[k] && (cnt_q[k] != '0);
      dec_last[k] = dec_eff[k] && (cnt_q[k] == CNT_WIDTH'(1));

      if (wr_hit[k] && hwlp_we_i[0]) start_d[k] = hwlp_start_data_i;
      if (wr_hit[k] && hwlp_we_i[1]) end_d[k]   = hwlp_end_data_i;

      // A counter write overrides any decrement, flush or completion on the same loop.
      if (wr_hit[k] && hwlp_we_i[2]) begin
        cnt_d[k]   = hwlp_cnt_data_i;
        armed_d[k] = |hwlp_cnt_data_i;
      end else begin
        if (dec_eff[k]) cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
        done_d[k] = dec_last[k];
        if (flush_i || dec_last[k]) armed_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_sel_val = '0;
    for (int k = 0; k < N_LOOPS; k++) begin
      if (rd_idx == 32'(k)) begin
        case (rd_sel_i)
          2'd0:    rd_sel_val = start_q[k];
          2'd1:    rd_sel_val = end_q[k];
          2'd2:    rd_sel_val = 32'(cnt_q[k]);
          default: rd_sel_val = {31'b0, armed_q[k]};
        endcase
      end
    end
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_en_i ? rd_sel_val : rd_data_q;
    // A new error wins over a simultaneous clear.
    if (dec_multi)      err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_LOOPS; k++) begin
        start_q[k] <= '0;
        end_q[k]   <= '0;
        cnt_q[k]   <= '0;
      end
      armed_q    <= '0;
      done_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int k = 0; k < N_LOOPS; k++) begin
        start_q[k] <= start_d[k];
        end_q[k]   <= end_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      armed_q    <= armed_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  for (genvar g = 0; g < N_LOOPS; g++) begin : g_out
    assign hwlp_start_addr_o[g*32 +: 32]             = start_q[g];
    assign hwlp_end_addr_o[g*32 +: 32]               = end_q[g];
    assign hwlp_counter_o[g*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[g];
  end

  assign hwlp_armed_o    = armed_q;
  assign hwlp_done_o     = done_q;
  assign rd_data_o       = rd_data_q;
  assign rd_valid_o      = rd_valid_q;
  assign multi_dec_err_o = err_q;

endmodule
